// File: rtl/com_link_uart.sv
// Link-side COM port UART: 68K byte writes are sent as 8N1 frames on LINK_TX, and frames on LINK_RX are queued for 68K reads.
// Optional COM_LINK_LOOPBACK_EN feeds LINK_TX back into the receiver instead of LINK_RX.
module com_link_uart #(
    parameter int DIV     = 768,
    parameter int FIFO_AW = 4
) (
    input  logic        CLK_48M,
    input  logic        nRESET,
    input  logic        nPORTOEL,
    input  logic        nPORTOEU,
    input  logic        nPORTWEL,
    input  logic [7:0]  M68K_DOUT,
    output logic [15:0] M68K_DIN,
    input  logic        LINK_RX,
    output logic        LINK_TX
);
    localparam int          DEPTH    = 1 << FIFO_AW;
    localparam logic [11:0] BIT_END  = 12'(DIV - 1);
    localparam logic [11:0] HALF_END = 12'(DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rxState_t;

    logic welPrev, oelPrev, oeuPrev;
    logic [7:0] wData;
    logic toggle, rxOvr;

    logic [7:0] txMem [DEPTH];
    logic [7:0] rxMem [DEPTH];
    logic [FIFO_AW:0] txWp, txRp, rxWp, rxRp;

    txState_t   txState;
    logic [11:0] txTimer;
    logic [2:0]  txBit;
    logic [7:0]  txShift;
    logic        txLine;

    rxState_t   rxState;
    logic [11:0] rxTimer;
    logic [2:0]  rxBit;
    logic [7:0]  rxShift;
    logic        rxMeta, rxS, rxSPrev, rxIn;

    wire welRise = !welPrev && nPORTWEL;
    wire oelRise = !oelPrev && nPORTOEL;
    wire oeuRise = !oeuPrev && nPORTOEU;

    wire txEmpty = (txWp == txRp);
    wire txFull  = (txWp[FIFO_AW] != txRp[FIFO_AW]) && (txWp[FIFO_AW-1:0] == txRp[FIFO_AW-1:0]);
    wire rxEmpty = (rxWp == rxRp);
    wire rxFull  = (rxWp[FIFO_AW] != rxRp[FIFO_AW]) && (rxWp[FIFO_AW-1:0] == rxRp[FIFO_AW-1:0]);
    wire [7:0] txHead = txMem[txRp[FIFO_AW-1:0]];
    wire [7:0] rxHead = rxMem[rxRp[FIFO_AW-1:0]];
    wire txBusy = (txState != TX_IDLE);

    wire txPush = welRise && !txFull;
    wire txPop  = !txEmpty && ((txState == TX_IDLE) || (txState == TX_STOP && txTimer == BIT_END));
    wire rxStopOk = (rxState == RX_STOP) && (rxTimer == BIT_END) && rxS;
    wire rxPush = rxStopOk && !rxFull;
    wire rxOvfl = rxStopOk && rxFull;
    wire rxPop  = oelRise && !rxEmpty;
    wire rxFall = rxSPrev && !rxS;

`ifdef COM_LINK_LOOPBACK_EN
    assign rxIn = txLine;
`else
    assign rxIn = LINK_RX;
`endif

    assign LINK_TX        = txLine;
    assign M68K_DIN[7:0]  = nPORTOEL ? 8'hzz : (rxEmpty ? 8'h00 : rxHead);
    assign M68K_DIN[15:8] = nPORTOEU ? 8'hzz : {rxOvr, txFull, rxEmpty, txBusy, toggle, 3'b000};

    always_ff @(posedge CLK_48M) begin
        if (txPush) txMem[txWp[FIFO_AW-1:0]] <= wData;
        if (rxPush) rxMem[rxWp[FIFO_AW-1:0]] <= rxShift;
    end

    // Strobe edges, write capture, status flags and FIFO pointers.
    always_ff @(posedge CLK_48M) begin
        if (!nRESET) begin
            welPrev <= 1'b1;
            oelPrev <= 1'b1;
            oeuPrev <= 1'b1;
            wData   <= 8'h00;
            toggle  <= 1'b0;
            rxOvr   <= 1'b0;
            txWp    <= '0;
            txRp    <= '0;
            rxWp    <= '0;
            rxRp    <= '0;
        end else begin
            welPrev <= nPORTWEL;
            oelPrev <= nPORTOEL;
            oeuPrev <= nPORTOEU;
            if (!nPORTWEL) wData <= M68K_DOUT;
            if (welRise) toggle <= !toggle;
            if (rxOvfl) rxOvr <= 1'b1;
            else if (oeuRise) rxOvr <= 1'b0;
            if (txPush) txWp <= txWp + 1'b1;
            if (txPop)  txRp <= txRp + 1'b1;
            if (rxPush) rxWp <= rxWp + 1'b1;
            if (rxPop)  rxRp <= rxRp + 1'b1;
        end
    end

    always_ff @(posedge CLK_48M) begin
        if (!nRESET) begin
            txState <= TX_IDLE;
            txLine  <= 1'b1;
            txTimer <= '0;
            txBit   <= '0;
            txShift <= '0;
        end else begin
            case (txState)
                TX_IDLE: begin
                    txLine  <= 1'b1;
                    txTimer <= '0;
                    if (!txEmpty) begin
                        txShift <= txHead;
                        txLine  <= 1'b0;
                        txState <= TX_START;
                    end
                end
                TX_START: begin
                    if (txTimer == BIT_END) begin
                        txTimer <= '0;
                        txBit   <= '0;
                        txLine  <= txShift[0];
                        txState <= TX_DATA;
                    end else txTimer <= txTimer + 12'd1;
                end
                TX_DATA: begin
                    if (txTimer == BIT_END) begin
                        txTimer <= '0;
                        if (txBit == 3'd7) begin
                            txLine  <= 1'b1;
                            txState <= TX_STOP;
                        end else begin
                            txBit   <= txBit + 3'd1;
                            txShift <= {1'b0, txShift[7:1]};
                            txLine  <= txShift[1];
                        end
                    end else txTimer <= txTimer + 12'd1;
                end
                TX_STOP: begin
                    if (txTimer == BIT_END) begin
                        txTimer <= '0;
                        // A queued byte follows the stop bit with no idle gap.
                        if (!txEmpty) begin
                            txShift <= txHead;
                            txLine  <= 1'b0;
                            txState <= TX_START;
                        end else txState <= TX_IDLE;
                    end else txTimer <= txTimer + 12'd1;
                end
                default: txState <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_48M) begin
        if (!nRESET) begin
            rxMeta  <= 1'b1;
            rxS     <= 1'b1;
            rxSPrev <= 1'b1;
            rxState <= RX_IDLE;
            rxTimer <= '0;
            rxBit   <= '0;
            rxShift <= '0;
        end else begin
            rxMeta  <= rxIn;
            rxS     <= rxMeta;
            rxSPrev <= rxS;
            case (rxState)
                RX_IDLE: begin
                    rxTimer <= '0;
                    if (rxFall) rxState <= RX_START;
                end
                RX_START: begin
                    // Mid start bit: a line back high here was only a glitch.
                    if (rxTimer == HALF_END) begin
                        rxTimer <= '0;
                        rxBit   <= '0;
                        rxState <= rxS ? RX_IDLE : RX_DATA;
                    end else rxTimer <= rxTimer + 12'd1;
                end
                RX_DATA: begin
                    if (rxTimer == BIT_END) begin
                        rxTimer <= '0;
                        rxShift <= {rxS, rxShift[7:1]};
                        if (rxBit == 3'd7) rxState <= RX_STOP;
                        else rxBit <= rxBit + 3'd1;
                    end else rxTimer <= rxTimer + 12'd1;
                end
                RX_STOP: begin
                    if (rxTimer == BIT_END) begin
                        rxTimer <= '0;
                        rxState <= rxS ? RX_IDLE : RX_WAIT;
                    end else rxTimer <= rxTimer + 12'd1;
                end
                RX_WAIT: begin
                    if (rxS) rxState <= RX_IDLE;
                end
                default: rxState <= RX_IDLE;
            endcase
        end
    end
endmodule
